// File: rtl/rac_pkg.sv
// Shared types for the redundancy-analysis scan controller: default widths,
// the stored repair-candidate entry layout and the controller state encoding.
package rac_pkg;

  localparam int RAC_ADDR_W = 10;
  localparam int RAC_BNK_W  = 2;

  typedef struct packed {
    logic [RAC_ADDR_W-1:0] addr;
    logic [RAC_BNK_W-1:0]  bnk;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rac_match.sv
// Redundancy-address comparator: decides whether one stored entry covers the
// latched fault. A nonzero rlss lets entries cover faults in other banks.
module rac_match #(
  parameter int ADDR_W = 10,
  parameter int BNK_W  = 2
) (
  input  logic [ADDR_W-1:0] ent_addr,
  input  logic [BNK_W-1:0]  ent_bnk,
  input  logic [ADDR_W-1:0] flt_addr,
  input  logic [BNK_W-1:0]  flt_bnk,
  input  logic [2:0]        rlss,
  output logic              match
);

  always_comb begin
    match = (ent_bnk != '0) && (flt_bnk != '0) && (ent_addr == flt_addr) &&
            ((rlss != 3'b000) || (ent_bnk == flt_bnk));
  end

endmodule

// File: rtl/rac_scan_ctrl.sv
// Scans the repair-candidate table one entry per cycle through a single shared
// comparator, reports hit/miss and allocates missed faults into the next free slot.
module rac_scan_ctrl
  import rac_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = RAC_ADDR_W,
  parameter int BNK_W   = RAC_BNK_W,
  localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int CNT_W  = $clog2(ENTRIES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        rlss,
  input  logic              clear,
  input  logic              flt_valid,
  output logic              flt_ready,
  input  logic [ADDR_W-1:0] flt_addr,
  input  logic [BNK_W-1:0]  flt_bnk,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [IDX_W-1:0]  rsp_idx,
  output logic              rsp_alloc,
  output logic              rsp_full,
  output logic [CNT_W-1:0]  used
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SCAN = SCAN;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]        state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [CNT_W-1:0]  used_reg;
  logic [ADDR_W-1:0] lat_addr_reg;
  logic [BNK_W-1:0]  lat_bnk_reg;
  logic [2:0]        lat_rlss_reg;
  logic              rsp_hit_reg;
  logic              rsp_alloc_reg;
  logic              rsp_full_reg;
  logic [IDX_W-1:0]  rsp_idx_reg;

  logic [ADDR_W-1:0] tbl_addr_reg [ENTRIES];
  logic [BNK_W-1:0]  tbl_bnk_reg  [ENTRIES];

  logic              accept;
  logic              tbl_clr;
  logic              match;
  logic              at_last;
  logic              has_room;
  logic [ADDR_W-1:0] cur_addr;
  logic [BNK_W-1:0]  cur_bnk;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [BNK_W-1:0]  wr_bnk;

  // rst is folded in so the state register's reset value cannot advertise readiness.
  always_comb begin
    flt_ready = (state_reg == ST_IDLE) && !clear && !rst;
    accept    = flt_valid && flt_ready;
    tbl_clr   = (state_reg == ST_IDLE) && clear;
    cur_addr  = tbl_addr_reg[idx_reg];
    cur_bnk   = tbl_bnk_reg[idx_reg];
    at_last   = (CNT_W'(idx_reg) == (used_reg - CNT_W'(1)));
    has_room  = (used_reg != CNT_W'(ENTRIES));
  end

  rac_match #(
    .ADDR_W(ADDR_W),
    .BNK_W (BNK_W)
  ) u_match (
    .ent_addr(cur_addr),
    .ent_bnk (cur_bnk),
    .flt_addr(lat_addr_reg),
    .flt_bnk (lat_bnk_reg),
    .rlss    (lat_rlss_reg),
    .match   (match)
  );

  // An empty table skips the scan, so that allocation writes straight from the inputs.
  always_comb begin
    wr_en   = 1'b0;
    wr_sel  = '0;
    wr_addr = lat_addr_reg;
    wr_bnk  = lat_bnk_reg;
    if ((state_reg == ST_IDLE) && accept && (flt_bnk != '0) && (used_reg == '0)) begin
      wr_en   = 1'b1;
      wr_addr = flt_addr;
      wr_bnk  = flt_bnk;
    end else if ((state_reg == ST_SCAN) && !match && at_last && has_room) begin
      wr_en  = 1'b1;
      wr_sel = IDX_W'(used_reg);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_tbl
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tbl_addr_reg[gi] <= '0;
          tbl_bnk_reg[gi]  <= '0;
        end else if (tbl_clr) begin
          tbl_bnk_reg[gi]  <= '0;
        end else if (wr_en && (wr_sel == IDX_W'(gi))) begin
          tbl_addr_reg[gi] <= wr_addr;
          tbl_bnk_reg[gi]  <= wr_bnk;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      used_reg      <= '0;
      lat_addr_reg  <= '0;
      lat_bnk_reg   <= '0;
      lat_rlss_reg  <= '0;
      rsp_hit_reg   <= 1'b0;
      rsp_alloc_reg <= 1'b0;
      rsp_full_reg  <= 1'b0;
      rsp_idx_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (clear) begin
            used_reg <= '0;
          end else if (accept) begin
            lat_addr_reg  <= flt_addr;
            lat_bnk_reg   <= flt_bnk;
            lat_rlss_reg  <= rlss;
            idx_reg       <= '0;
            rsp_hit_reg   <= 1'b0;
            rsp_alloc_reg <= 1'b0;
            rsp_full_reg  <= 1'b0;
            rsp_idx_reg   <= '0;
            if (flt_bnk == '0) begin
              state_reg <= ST_RESP;
            end else if (used_reg == '0) begin
              used_reg      <= CNT_W'(1);
              rsp_alloc_reg <= 1'b1;
              state_reg     <= ST_RESP;
            end else begin
              state_reg <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (match) begin
            rsp_hit_reg <= 1'b1;
            rsp_idx_reg <= idx_reg;
            state_reg   <= ST_RESP;
          end else if (at_last) begin
            state_reg <= ST_RESP;
            if (has_room) begin
              used_reg      <= used_reg + CNT_W'(1);
              rsp_alloc_reg <= 1'b1;
              rsp_idx_reg   <= IDX_W'(used_reg);
            end else begin
              rsp_full_reg <= 1'b1;
            end
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rsp_valid = (state_reg == ST_RESP);
    rsp_hit   = rsp_valid && rsp_hit_reg;
    rsp_alloc = rsp_valid && rsp_alloc_reg;
    rsp_full  = rsp_valid && rsp_full_reg;
    rsp_idx   = rsp_valid ? rsp_idx_reg : '0;
    used      = used_reg;
  end

endmodule

// File: tb/tb_rac_scan_ctrl.sv
// Directed bench for rac_scan_ctrl: allocation, hits, bank sharing, full table,
// clear, response stall, back-to-back traffic and reset during a scan.
module tb_rac_scan_ctrl;
  import rac_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rlss = 3'b000;
  logic       clear = 1'b0;
  logic       flt_valid = 1'b0;
  logic       flt_ready;
  logic [9:0] flt_addr = '0;
  logic [1:0] flt_bnk = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_hit;
  logic [2:0] rsp_idx;
  logic       rsp_alloc;
  logic       rsp_full;
  logic [3:0] used;

  int errors = 0;
  int checks = 0;

  // Captured response of the most recent transaction.
  int         r_lat;
  logic       r_hit, r_alloc, r_full;
  logic [2:0] r_idx;
  logic [3:0] r_used;

  always #5 clk = ~clk;

  rac_scan_ctrl #(.ENTRIES(8), .ADDR_W(10), .BNK_W(2)) dut (
    .clk(clk), .rst(rst), .rlss(rlss), .clear(clear),
    .flt_valid(flt_valid), .flt_ready(flt_ready), .flt_addr(flt_addr), .flt_bnk(flt_bnk),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx),
    .rsp_alloc(rsp_alloc), .rsp_full(rsp_full), .used(used)
  );

  // Offer one fault, flip rlss once accepted, and wait (bounded) for rsp_valid.
  // Latency counts the accept cycle as T, so 1 means valid in the cycle after accept.
  task automatic offer(input logic [9:0] a, input logic [1:0] b, input logic [2:0] r);
    entry_t e;
    e.addr = a;
    e.bnk  = b;
    @(negedge clk);
    flt_addr  = e.addr;
    flt_bnk   = e.bnk;
    rlss      = r;
    flt_valid = 1'b1;
    @(posedge clk);
    #1;
    flt_valid = 1'b0;
    rlss      = (r == 3'b000) ? 3'b111 : 3'b000;
    r_lat = 1;
    while (!rsp_valid && r_lat < 40) begin
      @(posedge clk);
      #1;
      r_lat++;
    end
    r_hit   = rsp_hit;
    r_alloc = rsp_alloc;
    r_full  = rsp_full;
    r_idx   = rsp_idx;
    r_used  = used;
    $display("txn addr=%03h bnk=%b rlss=%b lat=%0d hit=%b alloc=%b full=%b idx=%0d used=%0d",
             a, b, r, r_lat, r_hit, r_alloc, r_full, r_idx, r_used);
  endtask

  task automatic take_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_fault(input logic [9:0] a, input logic [1:0] b, input logic [2:0] r);
    offer(a, b, r);
    take_rsp();
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checks++;
    if (used !== 4'd0) begin
      errors++;
      $display("FAIL clear_used: got %0d want 0", used);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (flt_ready !== 1'b0 || rsp_valid !== 1'b0 || used !== 4'd0) begin
      errors++;
      $display("FAIL reset_ctl: ready=%b valid=%b used=%0d want 0 0 0", flt_ready, rsp_valid, used);
    end
    checks++;
    if (rsp_hit !== 1'b0 || rsp_alloc !== 1'b0 || rsp_full !== 1'b0 || rsp_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_rsp: hit=%b alloc=%b full=%b idx=%0d want all 0", rsp_hit, rsp_alloc, rsp_full, rsp_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (flt_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", flt_ready);
    end
  endtask

  task automatic test_alloc_first();
    do_fault(10'h155, 2'b01, 3'b000);
    checks++;
    if (r_lat != 1 || r_alloc !== 1'b1 || r_hit !== 1'b0 || r_idx !== 3'd0 || r_used !== 4'd1) begin
      errors++;
      $display("FAIL alloc_first: lat=%0d alloc=%b hit=%b idx=%0d used=%0d want 1 1 0 0 1",
               r_lat, r_alloc, r_hit, r_idx, r_used);
    end
  endtask

  task automatic test_hit();
    do_fault(10'h0A3, 2'b10, 3'b000);
    checks++;
    if (r_lat != 2 || r_alloc !== 1'b1 || r_idx !== 3'd1 || r_used !== 4'd2) begin
      errors++;
      $display("FAIL alloc_second: lat=%0d alloc=%b idx=%0d used=%0d want 2 1 1 2", r_lat, r_alloc, r_idx, r_used);
    end
    do_fault(10'h0A3, 2'b10, 3'b000);
    checks++;
    if (r_lat != 3 || r_hit !== 1'b1 || r_alloc !== 1'b0 || r_idx !== 3'd1 || r_used !== 4'd2) begin
      errors++;
      $display("FAIL hit_idx1: lat=%0d hit=%b alloc=%b idx=%0d used=%0d want 3 1 0 1 2",
               r_lat, r_hit, r_alloc, r_idx, r_used);
    end
  endtask

  task automatic test_rlss();
    do_clear();
    do_fault(10'h155, 2'b01, 3'b000);
    do_fault(10'h155, 2'b10, 3'b000);
    checks++;
    if (r_lat != 2 || r_hit !== 1'b0 || r_alloc !== 1'b1 || r_idx !== 3'd1) begin
      errors++;
      $display("FAIL rlss0_miss: lat=%0d hit=%b alloc=%b idx=%0d want 2 0 1 1", r_lat, r_hit, r_alloc, r_idx);
    end
    do_fault(10'h155, 2'b10, 3'b100);
    checks++;
    if (r_lat != 2 || r_hit !== 1'b1 || r_alloc !== 1'b0 || r_idx !== 3'd0 || r_used !== 4'd2) begin
      errors++;
      $display("FAIL rlss_share_hit: lat=%0d hit=%b alloc=%b idx=%0d used=%0d want 2 1 0 0 2",
               r_lat, r_hit, r_alloc, r_idx, r_used);
    end
  endtask

  task automatic test_full();
    do_clear();
    for (int i = 0; i < 8; i++) begin
      do_fault(10'h010 + 10'(i), 2'b01, 3'b000);
      checks++;
      if (r_lat != i + 1 || r_alloc !== 1'b1 || r_idx !== 3'(i) || r_used !== 4'(i + 1)) begin
        errors++;
        $display("FAIL fill_%0d: lat=%0d alloc=%b idx=%0d used=%0d want %0d 1 %0d %0d",
                 i, r_lat, r_alloc, r_idx, r_used, i + 1, i, i + 1);
      end
    end
    do_fault(10'h3FF, 2'b01, 3'b000);
    checks++;
    if (r_lat != 9 || r_full !== 1'b1 || r_alloc !== 1'b0 || r_hit !== 1'b0 || r_idx !== 3'd0 || r_used !== 4'd8) begin
      errors++;
      $display("FAIL full_drop: lat=%0d full=%b alloc=%b hit=%b idx=%0d used=%0d want 9 1 0 0 0 8",
               r_lat, r_full, r_alloc, r_hit, r_idx, r_used);
    end
    do_fault(10'h017, 2'b01, 3'b000);
    checks++;
    if (r_lat != 9 || r_hit !== 1'b1 || r_idx !== 3'd7) begin
      errors++;
      $display("FAIL hit_last: lat=%0d hit=%b idx=%0d want 9 1 7", r_lat, r_hit, r_idx);
    end
    do_clear();
  endtask

  task automatic test_bank0_stall();
    do_fault(10'h155, 2'b01, 3'b000);
    offer(10'h155, 2'b00, 3'b000);
    checks++;
    if (r_lat != 1 || r_hit !== 1'b0 || r_alloc !== 1'b0 || r_full !== 1'b0 || r_idx !== 3'd0) begin
      errors++;
      $display("FAIL bank0_rsp: lat=%0d hit=%b alloc=%b full=%b idx=%0d want 1 0 0 0 0",
               r_lat, r_hit, r_alloc, r_full, r_idx);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_alloc !== 1'b0 || rsp_full !== 1'b0 ||
          rsp_idx !== 3'd0 || flt_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: valid=%b hit=%b alloc=%b full=%b idx=%0d ready=%b want 1 0 0 0 0 0",
                 c, rsp_valid, rsp_hit, rsp_alloc, rsp_full, rsp_idx, flt_ready);
      end
    end
    take_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || flt_ready !== 1'b1 || used !== 4'd1) begin
      errors++;
      $display("FAIL after_handshake: valid=%b ready=%b used=%0d want 0 1 1", rsp_valid, flt_ready, used);
    end
    // rsp_ready in IDLE must be ignored
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || flt_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready_ignored: valid=%b ready=%b want 0 1", rsp_valid, flt_ready);
    end
    do_fault(10'h155, 2'b01, 3'b000);
    checks++;
    if (r_hit !== 1'b1 || r_idx !== 3'd0 || r_used !== 4'd1) begin
      errors++;
      $display("FAIL bank0_untouched: hit=%b idx=%0d used=%0d want 1 0 1", r_hit, r_idx, r_used);
    end
  endtask

  task automatic test_back_to_back();
    offer(10'h2C0, 2'b11, 3'b000);
    @(negedge clk);
    rsp_ready = 1'b1;
    flt_addr  = 10'h2C1;
    flt_bnk   = 2'b11;
    rlss      = 3'b000;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checks++;
    if (flt_ready !== 1'b1 || r_alloc !== 1'b1 || r_idx !== 3'd1) begin
      errors++;
      $display("FAIL b2b_first: ready=%b alloc=%b idx=%0d want 1 1 1", flt_ready, r_alloc, r_idx);
    end
    do_fault(10'h2C1, 2'b11, 3'b000);
    checks++;
    if (r_lat != 3 || r_alloc !== 1'b1 || r_idx !== 3'd2 || r_used !== 4'd3) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d alloc=%b idx=%0d used=%0d want 3 1 2 3", r_lat, r_alloc, r_idx, r_used);
    end
  endtask

  task automatic test_rst_mid_scan();
    do_clear();
    for (int i = 0; i < 5; i++) do_fault(10'h020 + 10'(i), 2'b01, 3'b000);
    @(negedge clk);
    flt_addr  = 10'h3AA;
    flt_bnk   = 2'b01;
    rlss      = 3'b000;
    flt_valid = 1'b1;
    @(posedge clk);
    #1;
    flt_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || flt_ready !== 1'b0 || used !== 4'd0 || rsp_hit !== 1'b0 ||
        rsp_alloc !== 1'b0 || rsp_full !== 1'b0 || rsp_idx !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid_scan: valid=%b ready=%b used=%0d hit=%b alloc=%b full=%b idx=%0d want all 0",
               rsp_valid, flt_ready, used, rsp_hit, rsp_alloc, rsp_full, rsp_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    do_fault(10'h020, 2'b01, 3'b000);
    checks++;
    if (r_lat != 1 || r_alloc !== 1'b1 || r_hit !== 1'b0 || r_idx !== 3'd0 || r_used !== 4'd1) begin
      errors++;
      $display("FAIL post_rst_alloc: lat=%0d alloc=%b hit=%b idx=%0d used=%0d want 1 1 0 0 1",
               r_lat, r_alloc, r_hit, r_idx, r_used);
    end
  endtask

  initial begin
    test_reset();
    test_alloc_first();
    test_hit();
    test_rlss();
    test_full();
    test_bank0_stall();
    test_back_to_back();
    test_rst_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rac_scan_ctrl.md
# rac_scan_ctrl

Sequencing controller for the built-in redundancy analysis datapath. It holds a table of stored repair-candidate entries (row/column address plus bank mask) and accepts one new pivot fault at a time over a valid/ready handshake. It scans the table one entry per cycle through a single shared redundancy-address comparator and returns hit/miss. On a miss it allocates the fault into the next free entry.

## Interface
Parameters:
- ENTRIES, 8: table depth, ≥1.
- ADDR_W, 10: address width.
- BNK_W, 2: bank mask width; mask 0 means "no bank / empty".

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rlss  in  3  repair-line-sharing select; sampled on fault accept.
- clear  in  1  synchronous table clear, honored only in IDLE.
- flt_valid  in  1  fault offered.
- flt_ready  out  1  controller can accept a fault.
- flt_addr  in  ADDR_W  fault address.
- flt_bnk  in  BNK_W  fault bank mask.
- rsp_valid  out  1  response valid, held until taken.
- rsp_ready  in  1  response consumer ready.
- rsp_hit  out  1  fault covered by a stored entry.
- rsp_idx  out  $clog2(ENTRIES)  hit index, or allocated index; 0 otherwise.
- rsp_alloc  out  1  fault written into table.
- rsp_full  out  1  miss with table full; fault dropped.
- used  out  $clog2(ENTRIES+1)  number of valid entries.

## Operation
- Match rule (per entry): entry bank ≠ 0 AND fault bank ≠ 0 AND entry addr == fault addr AND (latched rlss ≠ 0 OR entry bank == fault bank).
- The FSM has three states: IDLE, SCAN, RESP.
- IDLE:
  - flt_ready = 1 unless clear = 1.
  - clear = 1 takes priority over flt_valid: the next cycle has used = 0 and every entry bank = 0.
  - On handshake (flt_valid & flt_ready), latch flt_addr, flt_bnk and rlss, and set scan idx = 0.
  - If latched bank = 0: go to RESP with hit, alloc and full all 0.
  - Else if used = 0: allocate entry 0, set used = 1, and go to RESP with alloc = 1 and idx = 0.
  - Else go to SCAN.
- SCAN: compare entry[idx] each cycle.
  - First match: go to RESP with hit = 1 and idx = idx.
  - No match at idx = used−1: if used < ENTRIES, write the fault to entry[used], increment used, and go to RESP with alloc = 1 and idx = old used. Otherwise go to RESP with full = 1.
  - Otherwise increment idx.
- RESP:
  - rsp_valid = 1, and the rsp_* fields are stable.
  - rsp_valid & rsp_ready returns the FSM to IDLE.
- Entries are never removed individually; only clear or rst empties the table.
- used saturates at ENTRIES and never wraps.

## Timing
- Reset values:
  - flt_ready = 0 while rst is high.
  - rsp_valid, rsp_hit, rsp_alloc, rsp_full, rsp_idx and used are all 0.
  - State = IDLE, and all entry banks = 0.
- Accept at cycle T. Entry i is compared at cycle T+1+i.
- Hit on entry i: rsp_valid first high at T+2+i.
- Miss with used = n > 0: rsp_valid first high at T+1+n.
- used = 0 or bank = 0: rsp_valid first high at T+1.
- Allocation write and used update take effect on the same edge that enters RESP.
- Back-to-back operation: the earliest next accept is the cycle after the response handshake. flt_ready is 0 in SCAN and RESP.
- rsp_valid never drops without rsp_ready.
- rsp_ready asserted outside RESP is ignored.
- rst asserted mid-scan or in RESP aborts immediately: the pending response is lost and the table is emptied.
- A change of rlss after accept does not affect an in-flight scan.

## Structure
- Shared package rac_pkg holds:
  - ADDR_W and BNK_W defaults;
  - an entry struct {addr, bnk};
  - the FSM state enum {IDLE, SCAN, RESP}.
- Sub-module rac_match: purely combinational, implements the match rule for one entry against the latched fault. It is instantiated once and fed from a table mux at idx.
- The table is a register array, not SRAM, so reset and clear can empty it.

## Test plan
- Reset, then fault addr=0x155, bnk=01, rlss=0 → rsp at T+1 with alloc=1, idx=0, used=1.
- Entries {0x155/01, 0x0A3/10}; fault 0x0A3/10 → hit=1, idx=1, rsp_valid at T+3, used unchanged.
- Entry 0x155/01; fault 0x155/10 with rlss=0 → miss, alloc idx=1. Repeat with rlss=3'b100 → hit, idx=0.
- Fill 8 entries; new distinct fault → full=1 at T+9, used stays 8. Then clear → used=0 next cycle.
- Fault with bnk=00 → response at T+1, all flags 0, table untouched. Hold rsp_ready=0 for 5 cycles → rsp_valid and fields stable.
- Assert rst during SCAN at idx=3 → all outputs 0 immediately, used=0, and the next fault allocates idx 0.
